regbank_writeback: RTL and testbench

- Writeback queue that sits between the execute units and the register bank write port.
- Accepts results over a valid/ready handshake and buffers them in an in-order FIFO.
- Drains one entry per cycle onto the regbank write signals: write_enable, addr_z, data_z and z_regbank_sel.
- Exposes per-read-port hazard flags so decode can stall on registers with writes still pending.

---
 rtl/regbank_writeback.sv | 150 +++++++++++++++
 tb/tb_regbank_writeback.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_writeback.sv
// Writeback queue between the execute units and the register bank write port.
// Optional forwarding of pending data is enabled with `define REGBANK_WB_FORWARD_EN.
module regbank_writeback #(
    parameter int DEPTH        = 4,
    parameter int WIDTH        = 32,
    parameter int REG_SEL      = 5,
    parameter int PRED_REG_SEL = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    // in_valid/in_ready: an entry transfers on a rising edge where both are high;
    // while in_ready is low the producer holds in_valid and its payload stable.
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REG_SEL-1:0]       in_addr,
    input  logic                     in_bank_sel,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     flush,
    output logic                     write_enable,
    output logic [REG_SEL-1:0]       addr_z,
    output logic [WIDTH-1:0]         data_z,
    output logic                     z_regbank_sel,
    input  logic [REG_SEL-1:0]       chk_addr_a,
    input  logic [REG_SEL-1:0]       chk_addr_b,
    input  logic                     chk_sel_a,
    input  logic                     chk_sel_b,
    output logic                     hazard_a,
    output logic                     hazard_b,
    output logic [$clog2(DEPTH):0]   count
`ifdef REGBANK_WB_FORWARD_EN
    ,
    output logic [WIDTH-1:0]         fwd_data_a,
    output logic [WIDTH-1:0]         fwd_data_b
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [REG_SEL-1:0] addr;
        logic               sel;
        logic [WIDTH-1:0]   data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            we_q, we_d;
    entry_t          out_q, out_d;
    logic            push;
    logic            pop;

    // Ready looks only at occupancy, never at a same-cycle pop.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        we_d     = 1'b0;
        out_d    = out_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{addr: in_addr, sel: in_bank_sel, data: in_data};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                out_d    = mem_q[rd_ptr_q];
                we_d     = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            out_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            out_q    <= out_d;
        end
    end

    assign write_enable  = we_q;
    assign addr_z        = out_q.addr;
    assign data_z        = out_q.data;
    assign z_regbank_sel = out_q.sel;
    assign count         = count_q;

    // Predicate registers are addressed by their low PRED_REG_SEL bits only.
    function automatic logic addr_match(entry_t e, logic [REG_SEL-1:0] a, logic s);
        if (e.sel != s) return 1'b0;
        if (s) return e.addr[PRED_REG_SEL-1:0] == a[PRED_REG_SEL-1:0];
        return e.addr == a;
    endfunction

    always_comb begin
        hazard_a = we_q & addr_match(out_q, chk_addr_a, chk_sel_a);
        hazard_b = we_q & addr_match(out_q, chk_addr_b, chk_sel_b);
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                hazard_a = hazard_a | addr_match(mem_q[rd_ptr_q + AW'(i)], chk_addr_a, chk_sel_a);
                hazard_b = hazard_b | addr_match(mem_q[rd_ptr_q + AW'(i)], chk_addr_b, chk_sel_b);
            end
        end
    end

`ifdef REGBANK_WB_FORWARD_EN
    function automatic logic [WIDTH-1:0] wb_value(entry_t e);
        return e.sel ? WIDTH'(e.data[0]) : e.data;
    endfunction

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_data_a = '0;
        fwd_data_b = '0;
        if (we_q && addr_match(out_q, chk_addr_a, chk_sel_a)) fwd_data_a = wb_value(out_q);
        if (we_q && addr_match(out_q, chk_addr_b, chk_sel_b)) fwd_data_b = wb_value(out_q);
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (addr_match(mem_q[rd_ptr_q + AW'(i)], chk_addr_a, chk_sel_a))
                    fwd_data_a = wb_value(mem_q[rd_ptr_q + AW'(i)]);
                if (addr_match(mem_q[rd_ptr_q + AW'(i)], chk_addr_b, chk_sel_b))
                    fwd_data_b = wb_value(mem_q[rd_ptr_q + AW'(i)]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_regbank_writeback.sv
// Bench for regbank_writeback: queue-based reference model with a decoupled write-port monitor.
module tb_regbank_writeback;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int RS    = 5;
    localparam int PRED  = 3;

    typedef struct packed {
        logic [RS-1:0]    addr;
        logic             sel;
        logic [WIDTH-1:0] data;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [RS-1:0]    in_addr = '0;
    logic             in_bank_sel = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             flush = 1'b0;
    logic             write_enable;
    logic [RS-1:0]    addr_z;
    logic [WIDTH-1:0] data_z;
    logic             z_regbank_sel;
    logic [RS-1:0]    chk_addr_a = '0;
    logic [RS-1:0]    chk_addr_b = '0;
    logic             chk_sel_a = 1'b0;
    logic             chk_sel_b = 1'b0;
    logic             hazard_a;
    logic             hazard_b;
    logic [2:0]       count;
`ifdef REGBANK_WB_FORWARD_EN
    logic [WIDTH-1:0] fwd_data_a;
    logic [WIDTH-1:0] fwd_data_b;
`endif

    regbank_writeback #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REG_SEL(RS), .PRED_REG_SEL(PRED)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_bank_sel(in_bank_sel), .in_data(in_data), .flush(flush),
        .write_enable(write_enable), .addr_z(addr_z), .data_z(data_z),
        .z_regbank_sel(z_regbank_sel),
        .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
        .chk_sel_a(chk_sel_a), .chk_sel_b(chk_sel_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
`ifdef REGBANK_WB_FORWARD_EN
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
`endif
        .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: pending entries in age order plus the write-port stage
    ent_t              fifo_m[$];
    ent_t              out_m;
    bit                out_v = 1'b0;
    bit                accepted = 1'b0;
    logic [RS+WIDTH:0] exp_q[$];
    int                n_tests = 0;
    int                n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_match(ent_t e, logic [RS-1:0] a, logic s);
        if (e.sel != s) return 1'b0;
        if (s) return e.addr[PRED-1:0] == a[PRED-1:0];
        return e.addr == a;
    endfunction

    function automatic bit m_hit(logic [RS-1:0] a, logic s);
        bit h = out_v && m_match(out_m, a, s);
        foreach (fifo_m[i]) if (m_match(fifo_m[i], a, s)) h = 1'b1;
        return h;
    endfunction

    function automatic logic [WIDTH-1:0] m_fwd(logic [RS-1:0] a, logic s);
        logic [WIDTH-1:0] r = '0;
        for (int i = fifo_m.size() - 1; i >= 0; i--)
            if (m_match(fifo_m[i], a, s)) return fifo_m[i].sel ? {31'b0, fifo_m[i].data[0]} : fifo_m[i].data;
        if (out_v && m_match(out_m, a, s)) r = out_m.sel ? {31'b0, out_m.data[0]} : out_m.data;
        return r;
    endfunction

    task automatic model_step();
        ent_t cur;
        cur = '{addr: in_addr, sel: in_bank_sel, data: in_data};
        accepted = 1'b0;
        if (flush) begin
            fifo_m.delete();
            exp_q.delete();
            out_v = 1'b0;
        end else begin
            accepted = in_valid && (fifo_m.size() < DEPTH);
            if (fifo_m.size() > 0) begin
                out_m = fifo_m.pop_front();
                out_v = 1'b1;
            end else begin
                out_v = 1'b0;
            end
            if (accepted) begin
                fifo_m.push_back(cur);
                exp_q.push_back(cur);
            end
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        exp_q.delete();
        out_v = 1'b0;
        accepted = 1'b0;
    endtask

    task automatic check_outputs();
        chk("count", 64'(count), 64'(fifo_m.size()));
        chk("in_ready", 64'(in_ready), 64'(fifo_m.size() != DEPTH));
        chk("write_enable", 64'(write_enable), 64'(out_v));
        chk("hazard_a", 64'(hazard_a), 64'(m_hit(chk_addr_a, chk_sel_a)));
        chk("hazard_b", 64'(hazard_b), 64'(m_hit(chk_addr_b, chk_sel_b)));
`ifdef REGBANK_WB_FORWARD_EN
        chk("fwd_data_a", 64'(fwd_data_a), 64'(m_fwd(chk_addr_a, chk_sel_a)));
        chk("fwd_data_b", 64'(fwd_data_b), 64'(m_fwd(chk_addr_b, chk_sel_b)));
`endif
    endtask

    // driver
    task automatic do_cycle(input bit v, input logic [RS-1:0] a, input bit s,
                            input logic [WIDTH-1:0] d, input bit f);
        in_valid = v;
        in_addr = a;
        in_bank_sel = s;
        in_data = d;
        flush = f;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_chk(input logic [RS-1:0] aa, input bit sa, input logic [RS-1:0] ab, input bit sb);
        chk_addr_a = aa;
        chk_sel_a = sa;
        chk_addr_b = ab;
        chk_sel_b = sb;
    endtask

    // scoreboard monitor: every write strobe must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && write_enable) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, no write expected", addr_z, data_z);
            end else begin
                chk("write_port", 64'({addr_z, z_regbank_sel, data_z}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               v;
        bit               s;
        bit               f;
        logic [RS-1:0]    a;
        logic [WIDTH-1:0] d;
        bit               hold;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs();
        chk("reset_addr_z", 64'(addr_z), 64'd0);
        chk("reset_data_z", 64'(data_z), 64'd0);
        chk("reset_sel_z", 64'(z_regbank_sel), 64'd0);

        // single entry latency and hazard window
        set_chk(5'd3, 1'b0, 5'd3, 1'b1);
        do_cycle(1'b1, 5'd3, 1'b0, 32'hDEADBEEF, 1'b0);
        chk("t1_hazard_pending", 64'(hazard_a), 64'd1);
        do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
        chk("t1_we", 64'(write_enable), 64'd1);
        chk("t1_addr", 64'(addr_z), 64'd3);
        do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
        chk("t1_we_off", 64'(write_enable), 64'd0);
        chk("t1_hazard_clear", 64'(hazard_a), 64'd0);

        // back-to-back stream
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 5'(i + 8), 1'b0, 32'(i * 7 + 1), 1'b0);
        repeat (2) do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

        // bank select and predicate address aliasing
        set_chk(5'd5, 1'b1, 5'd13, 1'b0);
        do_cycle(1'b1, 5'd5, 1'b0, 32'h55, 1'b0);
        do_cycle(1'b1, 5'd5, 1'b1, 32'h3, 1'b0);
        chk("t3_hazard_pred", 64'(hazard_a), 64'd1);
        chk("t3_hazard_13_scalar", 64'(hazard_b), 64'd0);
        set_chk(5'd13, 1'b1, 5'd6, 1'b1);
        do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
        chk("t3_hazard_13_pred", 64'(hazard_a), 64'd1);
        repeat (2) do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

        // flush while an entry sits on the write port; the same-cycle push is dropped
        set_chk(5'd20, 1'b0, 5'd21, 1'b0);
        do_cycle(1'b1, 5'd20, 1'b0, 32'hA, 1'b0);
        do_cycle(1'b1, 5'd21, 1'b0, 32'hB, 1'b0);
        chk("t4_a_on_port", 64'(addr_z), 64'd20);
        do_cycle(1'b1, 5'd22, 1'b0, 32'hC, 1'b1);
        chk("t4_count_flushed", 64'(count), 64'd0);
        chk("t4_hazard_b_clear", 64'(hazard_b), 64'd0);
        repeat (3) do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

        // youngest-match forwarding on a register written twice
        set_chk(5'd7, 1'b0, 5'd7, 1'b1);
        do_cycle(1'b1, 5'd7, 1'b0, 32'h11, 1'b0);
        do_cycle(1'b1, 5'd7, 1'b0, 32'h22, 1'b0);
        repeat (3) do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

        // randomized traffic with occasional flushes
        hold = 1'b0;
        v = 1'b0; s = 1'b0; f = 1'b0; a = '0; d = '0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                a = 5'($urandom_range(0, 15));
                s = 1'($urandom_range(0, 1));
                d = $urandom;
            end
            f = ($urandom_range(0, 15) == 0);
            set_chk(5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            do_cycle(v, a, s, d, f);
            hold = v && !accepted && !f;
        end
        repeat (2) do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

        // asynchronous reset while an entry is being written
        set_chk(5'd9, 1'b0, 5'd9, 1'b0);
        do_cycle(1'b1, 5'd9, 1'b0, 32'h99, 1'b0);
        do_cycle(1'b1, 5'd10, 1'b0, 32'hAA, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        model_step();
        #2;
        chk("t6_we_before_reset", 64'(write_enable), 64'd1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("t6_we_async", 64'(write_enable), 64'd0);
        chk("t6_count_async", 64'(count), 64'd0);
        chk("t6_hazard_async", 64'(hazard_a), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) do_cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
